// File: rtl/mcb_cmd_arbiter_if.sv
// rtl/mcb_cmd_arbiter_if.sv - requester bundle and MCB command port shared by the arbiter
interface mcb_cmd_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 30
);
    logic [N_REQ-1:0]        req;
    logic [3*N_REQ-1:0]      req_instr;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [6*N_REQ-1:0]      req_bl;
    logic [N_REQ-1:0]        grant;
    logic                    cmd_en;
    logic [2:0]              cmd_instr;
    logic [ADDR_W-1:0]       cmd_addr;
    logic [5:0]              cmd_bl;
    logic                    cmd_full;

    modport master (
        output req, req_instr, req_addr, req_bl, cmd_full,
        input  grant, cmd_en, cmd_instr, cmd_addr, cmd_bl
    );

    modport slave (
        input  req, req_instr, req_addr, req_bl, cmd_full,
        output grant, cmd_en, cmd_instr, cmd_addr, cmd_bl
    );
endinterface

// File: rtl/mcb_cmd_arbiter.sv
// rtl/mcb_cmd_arbiter.sv - round-robin arbiter for one MCB command port, gated by PLL lock and calibration
module mcb_cmd_arbiter #(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = 30,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk0,
    input  logic                 sys_rst_n,
    input  logic                 pll_lock,
    input  logic                 calib_done,
    mcb_cmd_arbiter_if.slave     bus,
    output logic                 ready,
    output logic                 stall_err,
    output logic                 calib_lost,
    output logic [15:0]          cmd_count
);
    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(TIMEOUT_CYC);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);

    localparam logic [1:0] S_CALIB = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_win;
    logic [STALL_W-1:0] r_stall;
    logic [2:0]         r_instr;
    logic [ADDR_W-1:0]  r_addr;
    logic [5:0]         r_bl;
    logic               r_stall_err;
    logic               r_calib_lost;
    logic [15:0]        r_count;

    logic               w_locked;
    logic               w_cmd_en;
    logic               w_any;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_sel;
    logic [2:0]         w_instr;
    logic [ADDR_W-1:0]  w_addr;
    logic [5:0]         w_bl;

    assign w_locked = pll_lock & calib_done;
    // Loss of lock or reset kills the enable in the same cycle, not one edge later.
    assign w_cmd_en = (r_state == S_ISSUE) & ~bus.cmd_full & w_locked & sys_rst_n;

    // Walk downward so the lowest offset from r_ptr is the last (winning) write.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_ptr;
        w_idx = r_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (bus.req[w_idx]) begin
                w_any = 1'b1;
                w_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_instr = '0;
        w_addr  = '0;
        w_bl    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_sel == PTR_W'(k)) begin
                w_instr = bus.req_instr[3*k +: 3];
                w_addr  = bus.req_addr[ADDR_W*k +: ADDR_W];
                w_bl    = bus.req_bl[6*k +: 6];
            end
        end
    end

    always_comb begin
        bus.grant = '0;
        if (w_cmd_en) bus.grant[r_win] = 1'b1;
    end

    always_ff @(posedge clk0) begin
        if (!sys_rst_n) begin
            r_state      <= S_CALIB;
            r_ptr        <= '0;
            r_win        <= '0;
            r_stall      <= '0;
            r_instr      <= '0;
            r_addr       <= '0;
            r_bl         <= '0;
            r_stall_err  <= 1'b0;
            r_calib_lost <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_CALIB: if (w_locked) r_state <= S_IDLE;
                S_IDLE: begin
                    if (!w_locked) begin
                        r_state      <= S_CALIB;
                        r_calib_lost <= 1'b1;
                    end else if (w_any) begin
                        r_instr <= w_instr;
                        r_addr  <= w_addr;
                        r_bl    <= w_bl;
                        r_win   <= w_sel;
                        r_stall <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A discarded command is simply re-arbitrated later, since req stays high.
                    if (!w_locked) begin
                        r_state      <= S_CALIB;
                        r_calib_lost <= 1'b1;
                    end else if (w_cmd_en) begin
                        r_ptr   <= (r_win == PTR_LAST) ? '0 : r_win + 1'b1;
                        r_count <= r_count + 16'd1;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_stall != STALL_MAX) r_stall <= r_stall + 1'b1;
                        if (r_stall == STALL_LAST) r_stall_err <= 1'b1;
                    end
                end
                default: r_state <= S_CALIB;
            endcase
        end
    end

    assign bus.cmd_en    = w_cmd_en;
    assign bus.cmd_instr = r_instr;
    assign bus.cmd_addr  = r_addr;
    assign bus.cmd_bl    = r_bl;
    assign ready         = (r_state != S_CALIB);
    assign stall_err     = r_stall_err;
    assign calib_lost    = r_calib_lost;
    assign cmd_count     = r_count;
endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// tb/tb_mcb_cmd_arbiter.sv - directed bench with a per-cycle behavioural model of the arbiter
module tb_mcb_cmd_arbiter;
    localparam int N  = 3;
    localparam int AW = 30;
    localparam int TO = 12;

    logic        clk0 = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        pll_lock = 1'b0;
    logic        calib_done = 1'b0;
    logic        ready, stall_err, calib_lost;
    logic [15:0] cmd_count;

    mcb_cmd_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

    mcb_cmd_arbiter #(.N_REQ(N), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk0       (clk0),
        .sys_rst_n  (sys_rst_n),
        .pll_lock   (pll_lock),
        .calib_done (calib_done),
        .bus        (bus.slave),
        .ready      (ready),
        .stall_err  (stall_err),
        .calib_lost (calib_lost),
        .cmd_count  (cmd_count)
    );

    always #5 clk0 = ~clk0;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int n_en  = 0;

    logic [2:0]    f_instr [N];
    logic [AW-1:0] f_addr  [N];
    logic [5:0]    f_bl    [N];

    always @(posedge clk0) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk0);
        #1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g, output int at);
        g  = '0;
        at = -1;
        for (int i = 0; i < 50; i++) begin
            if (bus.grant != '0) begin
                g  = bus.grant;
                at = cyc;
                step(1);
                return;
            end
            step(1);
        end
        n_chk++;
        n_err++;
        $display("FAIL grant_timeout actual=none required=grant within 50 cycles");
    endtask

    // Behavioural model: memory usable flag, one optional pending command, rotation pointer.
    bit          m_valid = 0;
    bit          m_ready, m_pending, m_err, m_lost;
    int          m_ptr, m_win, m_stall;
    logic [15:0] m_count;
    logic [2:0]    m_instr;
    logic [AW-1:0] m_addr;
    logic [5:0]    m_bl;

    always @(negedge clk0) begin : model
        bit e_en;
        int rq;
        int e_grant;
        rq      = int'(bus.req);
        e_en    = m_pending && !bus.cmd_full && pll_lock && calib_done && sys_rst_n;
        e_grant = e_en ? (1 << m_win) : 0;
        if (bus.cmd_en) n_en++;
        if (m_valid) begin
            check("cmd_en",     64'(bus.cmd_en),    64'(e_en));
            check("grant",      64'(bus.grant),     64'(e_grant));
            check("ready",      64'(ready),         64'(m_ready));
            check("cmd_instr",  64'(bus.cmd_instr), 64'(m_instr));
            check("cmd_addr",   64'(bus.cmd_addr),  64'(m_addr));
            check("cmd_bl",     64'(bus.cmd_bl),    64'(m_bl));
            check("stall_err",  64'(stall_err),     64'(m_err));
            check("calib_lost", 64'(calib_lost),    64'(m_lost));
            check("cmd_count",  64'(cmd_count),     64'(m_count));
        end
        if (!sys_rst_n) begin
            m_valid = 1; m_ready = 0; m_pending = 0; m_err = 0; m_lost = 0;
            m_ptr = 0; m_win = 0; m_stall = 0; m_count = '0;
            m_instr = '0; m_addr = '0; m_bl = '0;
        end else if (!m_ready) begin
            m_ready = pll_lock && calib_done;
        end else if (!(pll_lock && calib_done)) begin
            m_ready = 0; m_pending = 0; m_lost = 1;
        end else if (m_pending) begin
            if (!bus.cmd_full) begin
                m_ptr = (m_win + 1) % N;
                m_count++;
                m_pending = 0;
            end else begin
                m_stall++;
                if (m_stall >= TO) m_err = 1;
            end
        end else if (rq != 0) begin
            for (int k = N - 1; k >= 0; k--)
                if (((rq >> ((m_ptr + k) % N)) & 1) != 0) m_win = (m_ptr + k) % N;
            m_pending = 1;
            m_instr = f_instr[m_win];
            m_addr  = f_addr[m_win];
            m_bl    = f_bl[m_win];
            m_stall = 0;
        end
    end

    initial begin : stim
        logic [N-1:0] g;
        int at, prev, ne;
        int exp_order [6];
        exp_order = '{2, 4, 1, 2, 4, 1};
        for (int i = 0; i < N; i++) begin
            f_instr[i] = 3'(i + 3);
            f_addr[i]  = AW'(32'h0123_4560 * (i + 1));
            f_bl[i]    = 6'(7 * i + 5);
            bus.req_instr[3*i +: 3]   = f_instr[i];
            bus.req_addr[AW*i +: AW]  = f_addr[i];
            bus.req_bl[6*i +: 6]      = f_bl[i];
        end
        bus.req = '0;
        bus.cmd_full = 1'b0;
        pll_lock = 1'b1;

        step(2);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_cmd_en", 64'(bus.cmd_en), 64'd0);
        check("rst_count", 64'(cmd_count), 64'd0);
        check("rst_addr", 64'(bus.cmd_addr), 64'd0);

        // Bring-up: calibration still pending holds off the request.
        sys_rst_n = 1'b1;
        bus.req = 3'b001;
        step(5);
        check("bringup_ready", 64'(ready), 64'd0);
        check("bringup_no_en", 64'(n_en), 64'd0);
        calib_done = 1'b1;
        wait_grant(g, at);
        bus.req = '0;
        check("bringup_grant", 64'(g), 64'b001);
        check("bringup_addr", 64'(bus.cmd_addr), 64'h0123_4560);
        check("bringup_count", 64'(cmd_count), 64'd1);

        // Fairness: pointer sits at 1 after the first grant.
        bus.req = 3'b111;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            wait_grant(g, at);
            check("fair_order", 64'(g), 64'(exp_order[i]));
            if (i > 0) check("fair_gap", 64'(at - prev), 64'd2);
            prev = at;
        end
        bus.req = '0;
        check("fair_count", 64'(cmd_count), 64'd7);

        // Backpressure below the timeout.
        bus.cmd_full = 1'b1;
        bus.req = 3'b010;
        step(1);
        ne = n_en;
        step(10);
        check("bp_no_en", 64'(n_en), 64'(ne));
        check("bp_stall_err", 64'(stall_err), 64'd0);
        check("bp_addr", 64'(bus.cmd_addr), 64'(f_addr[1]));
        bus.cmd_full = 1'b0;
        #1;
        check("bp_release_grant", 64'(bus.grant), 64'b010);
        step(1);
        bus.req = '0;

        // Stall timeout boundary: clear after TO-1 full cycles, set after TO.
        bus.cmd_full = 1'b1;
        bus.req = 3'b100;
        step(1);
        step(TO - 1);
        check("stall_before", 64'(stall_err), 64'd0);
        step(1);
        check("stall_at", 64'(stall_err), 64'd1);
        step(3);
        bus.cmd_full = 1'b0;
        #1;
        check("stall_release_grant", 64'(bus.grant), 64'b100);
        step(1);
        bus.req = '0;
        check("stall_sticky", 64'(stall_err), 64'd1);

        // Calibration loss mid-ISSUE, with cmd_full dropping in the same cycle.
        bus.cmd_full = 1'b1;
        bus.req = 3'b001;
        step(3);
        calib_done = 1'b0;
        bus.cmd_full = 1'b0;
        #1;
        check("loss_cmd_en", 64'(bus.cmd_en), 64'd0);
        check("loss_grant", 64'(bus.grant), 64'd0);
        step(1);
        check("loss_flag", 64'(calib_lost), 64'd1);
        check("loss_ready", 64'(ready), 64'd0);
        ne = n_en;
        step(3);
        calib_done = 1'b1;
        wait_grant(g, at);
        bus.req = '0;
        check("loss_regrant", 64'(g), 64'b001);
        step(4);
        check("loss_once", 64'(n_en), 64'(ne + 1));

        // Reset during ISSUE.
        bus.cmd_full = 1'b1;
        bus.req = 3'b010;
        step(1);
        sys_rst_n = 1'b0;
        bus.cmd_full = 1'b0;
        #1;
        check("rst_cycle_no_en", 64'(bus.cmd_en), 64'd0);
        step(1);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_stall", 64'(stall_err), 64'd0);
        check("midrst_lost", 64'(calib_lost), 64'd0);
        check("midrst_count", 64'(cmd_count), 64'd0);
        check("midrst_bl", 64'(bus.cmd_bl), 64'd0);
        sys_rst_n = 1'b1;
        step(1);
        check("post_rst_ready", 64'(ready), 64'd1);
        wait_grant(g, at);
        bus.req = '0;
        check("post_rst_grant", 64'(g), 64'b010);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
